// File: rtl/pwm_multi.sv
// pwm_multi: shared prescaler / PWM period / ramp-step timebase driving
// CHANNELS independent PWM outputs. Each channel is OFF, STATIC, SAW or
// TRIANGLE. Levels ramp on STEP, and the compared duty is latched only at
// period boundaries so every output period is glitch-free.
module pwm_multi #(
  parameter int CHANNELS     = 4,
  parameter int WIDTH        = 5,
  parameter int PRESCALE     = 128,
  parameter int RAMP_PERIODS = 128,
  localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                CLK_3p33MHZ,
  input  logic                RST,
  input  logic                WR_EN,
  input  logic [CH_W-1:0]     WR_CH,
  input  logic [1:0]          WR_MODE,
  input  logic [WIDTH-1:0]    WR_DUTY,
  output logic [CHANNELS-1:0] PWM_OUT,
  output logic                TICK,
  output logic                PERIOD_START,
  output logic                STEP
);

  localparam int PS_W = $clog2(PRESCALE);
  localparam int PC_W = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;

  localparam logic [PS_W-1:0]  PRESC_LAST = PS_W'(PRESCALE - 1);
  localparam logic [PC_W-1:0]  PCNT_LAST  = PC_W'(RAMP_PERIODS - 1);
  localparam logic [WIDTH-1:0] LEVEL_MAX  = '1;
  localparam logic [CH_W:0]    CH_LIMIT   = (CH_W + 1)'(CHANNELS);

  localparam logic [1:0] MODE_OFF    = 2'b00;
  localparam logic [1:0] MODE_STATIC = 2'b01;
  localparam logic [1:0] MODE_SAW    = 2'b10;
  localparam logic [1:0] MODE_TRI    = 2'b11;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  logic [PS_W-1:0]     presc;
  logic [WIDTH-1:0]    cnt;
  logic [PC_W-1:0]     pcnt;

  logic [1:0]          mode        [CHANNELS];
  logic [WIDTH-1:0]    level       [CHANNELS];
  logic [WIDTH-1:0]    active_duty [CHANNELS];
  logic [CHANNELS-1:0] dir;

  logic [WIDTH-1:0]    level_nxt   [CHANNELS];
  logic [CHANNELS-1:0] dir_nxt;
  logic [CHANNELS-1:0] wr_hit;
  logic                wr_ok;

  // Strobes are pure decodes of the registered counters, so they read 0 while
  // the counters sit in reset.
  assign TICK         = (presc == PRESC_LAST);
  assign PERIOD_START = TICK && (cnt == LEVEL_MAX);
  assign STEP         = PERIOD_START && (pcnt == PCNT_LAST);

  // Out-of-range channel numbers must not touch any channel.
  assign wr_ok = WR_EN && ({1'b0, WR_CH} < CH_LIMIT);

  // Timebase: prescaler, PWM counter and ramp period counter.
  // NOTE: all state here uses non-blocking assignment so every register samples
  // pre-edge values; blocking writes would let later statements see new ones.
  always_ff @(posedge CLK_3p33MHZ) begin
    if (RST) begin
      presc <= '0;
      cnt   <= '0;
      pcnt  <= '0;
    end else begin
      presc <= TICK ? '0 : presc + 1'b1;
      if (TICK) cnt <= cnt + 1'b1;
      if (PERIOD_START) pcnt <= (pcnt == PCNT_LAST) ? '0 : pcnt + 1'b1;
    end
  end

  // Per-channel write decode and the level each ramp mode moves to on STEP.
  // NOTE: every output of this block gets a default first so no path leaves a
  // value held, which would otherwise infer a latch.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      wr_hit[i]    = wr_ok && (WR_CH == CH_W'(i));
      level_nxt[i] = level[i];
      dir_nxt[i]   = dir[i];
      case (mode[i])
        MODE_SAW: level_nxt[i] = level[i] + 1'b1;
        MODE_TRI: begin
          if (dir[i] == DIR_UP) begin
            if (level[i] == LEVEL_MAX) begin
              dir_nxt[i]   = DIR_DOWN;
              level_nxt[i] = LEVEL_MAX - 1'b1;
            end else begin
              level_nxt[i] = level[i] + 1'b1;
            end
          end else begin
            if (level[i] == '0) begin
              dir_nxt[i]   = DIR_UP;
              level_nxt[i] = WIDTH'(1);
            end else begin
              level_nxt[i] = level[i] - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Channel state, period-aligned duty capture and registered PWM compare.
  // A write to a channel wins over its own ramp step on the same clock.
  // NOTE: the per-channel arrays are a handful of flops, not a RAM, so each
  // element is reset explicitly to give a known mode/level/dir after RST.
  always_ff @(posedge CLK_3p33MHZ) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (RST) begin
        mode[i]        <= MODE_OFF;
        level[i]       <= '0;
        dir[i]         <= DIR_UP;
        active_duty[i] <= '0;
        PWM_OUT[i]     <= 1'b0;
      end else begin
        if (wr_hit[i]) begin
          mode[i]  <= WR_MODE;
          level[i] <= WR_DUTY;
          dir[i]   <= DIR_UP;
        end else if (STEP) begin
          level[i] <= level_nxt[i];
          dir[i]   <= dir_nxt[i];
        end
        if (PERIOD_START) active_duty[i] <= level[i];
        PWM_OUT[i] <= (mode[i] != MODE_OFF) && (cnt < active_duty[i]);
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: scoreboard bench for pwm_multi. Expected high-clock counts per
// PWM period are queued when a channel is written and compared when the DUT
// signals the period boundary. A second instance (3 channels, 3-period ramp)
// covers invalid channel numbers and the slower STEP cadence.
module tb_pwm_multi;

  localparam int PERIOD = 32;  // PRESCALE * 2^WIDTH

  localparam logic [1:0] MODE_OFF    = 2'b00;
  localparam logic [1:0] MODE_STATIC = 2'b01;
  localparam logic [1:0] MODE_SAW    = 2'b10;
  localparam logic [1:0] MODE_TRI    = 2'b11;

  typedef struct {
    int c0;
    int c1;
    int c2;
  } exp_t;  // expected high clocks per channel in one period, -1 = don't care

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic       wr_ch = 1'b0;
  logic [1:0] wr_mode = 2'b00;
  logic [2:0] wr_duty = 3'd0;
  logic [1:0] pwm_out;
  logic       tick, period_start, step;

  logic       wr_en_b = 1'b0;
  logic [1:0] wr_ch_b = 2'd0;
  logic [2:0] pwm_out_b;
  logic       tick_b, period_start_b, step_b;

  exp_t exp_q[$];
  exp_t exp_b_q[$];
  int   acc [2];
  int   acc_b [3];
  int   k;
  int   n_checks = 0;
  int   n_fail = 0;

  pwm_multi #(.CHANNELS(2), .WIDTH(3), .PRESCALE(4), .RAMP_PERIODS(1)) dut (
    .CLK_3p33MHZ (clk),
    .RST         (rst),
    .WR_EN       (wr_en),
    .WR_CH       (wr_ch),
    .WR_MODE     (wr_mode),
    .WR_DUTY     (wr_duty),
    .PWM_OUT     (pwm_out),
    .TICK        (tick),
    .PERIOD_START(period_start),
    .STEP        (step)
  );

  pwm_multi #(.CHANNELS(3), .WIDTH(3), .PRESCALE(4), .RAMP_PERIODS(3)) dut_b (
    .CLK_3p33MHZ (clk),
    .RST         (rst),
    .WR_EN       (wr_en_b),
    .WR_CH       (wr_ch_b),
    .WR_MODE     (wr_mode),
    .WR_DUTY     (wr_duty),
    .PWM_OUT     (pwm_out_b),
    .TICK        (tick_b),
    .PERIOD_START(period_start_b),
    .STEP        (step_b)
  );

  initial forever #5 clk = ~clk;

  function automatic exp_t mk(input int a, input int b, input int c);
    exp_t r;
    r.c0 = a;
    r.c1 = b;
    r.c2 = c;
    return r;
  endfunction

  // Advance to the next falling edge, accumulate outputs, and at each period
  // boundary pop the scoreboard entry for the window that just ended.
  task automatic tick_neg();
    exp_t e;
    @(negedge clk);
    if (rst) begin
      k = 0;
      acc[0] = 0; acc[1] = 0;
      acc_b[0] = 0; acc_b[1] = 0; acc_b[2] = 0;
    end else begin
      k++;
      for (int i = 0; i < 2; i++) acc[i] += int'(pwm_out[i]);
      for (int i = 0; i < 3; i++) acc_b[i] += int'(pwm_out_b[i]);
      if (period_start) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          if (e.c0 >= 0) begin
            n_checks++;
            if (acc[0] !== e.c0) begin
              n_fail++;
              $display("FAIL sb_main ch0 k=%0d: high %0d clocks, expected %0d", k, acc[0], e.c0);
            end
          end
          if (e.c1 >= 0) begin
            n_checks++;
            if (acc[1] !== e.c1) begin
              n_fail++;
              $display("FAIL sb_main ch1 k=%0d: high %0d clocks, expected %0d", k, acc[1], e.c1);
            end
          end
        end
        acc[0] = 0; acc[1] = 0;
      end
      if (period_start_b) begin
        if (exp_b_q.size() > 0) begin
          e = exp_b_q.pop_front();
          n_checks++;
          if (acc_b[0] !== e.c0 || acc_b[1] !== e.c1 || acc_b[2] !== e.c2) begin
            n_fail++;
            $display("FAIL sb_b k=%0d: high %0d/%0d/%0d clocks, expected %0d/%0d/%0d",
                     k, acc_b[0], acc_b[1], acc_b[2], e.c0, e.c1, e.c2);
          end
        end
        acc_b[0] = 0; acc_b[1] = 0; acc_b[2] = 0;
      end
    end
  endtask

  // Run until the main instance flags a period boundary (bounded).
  task automatic wait_ps();
    bit seen = 1'b0;
    for (int n = 0; n < 3 * PERIOD && !seen; n++) begin
      tick_neg();
      seen = period_start;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_ps: no PERIOD_START within %0d clocks", 3 * PERIOD);
    end
  endtask

  task automatic write_main(input logic ch, input logic [1:0] m, input logic [2:0] d);
    wr_en = 1'b1; wr_ch = ch; wr_mode = m; wr_duty = d;
    tick_neg();
    wr_en = 1'b0;
  endtask

  task automatic write_b(input logic [1:0] ch, input logic [1:0] m, input logic [2:0] d);
    wr_en_b = 1'b1; wr_ch_b = ch; wr_mode = m; wr_duty = d;
    tick_neg();
    wr_en_b = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick_neg();
    n_checks++;
    if (pwm_out !== 2'b00 || tick !== 1'b0 || period_start !== 1'b0 || step !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_main: pwm=%b tick=%b ps=%b step=%b, expected all 0", pwm_out, tick, period_start, step);
    end
    n_checks++;
    if (pwm_out_b !== 3'b000 || tick_b !== 1'b0 || period_start_b !== 1'b0 || step_b !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_b: pwm=%b tick=%b ps=%b step=%b, expected all 0", pwm_out_b, tick_b, period_start_b, step_b);
    end
  endtask

  task automatic test_idle();
    logic exp_tick, exp_ps;
    exp_q.push_back(mk(0, 0, -1));
    exp_q.push_back(mk(0, 0, -1));
    exp_b_q.push_back(mk(0, 0, 0));
    exp_b_q.push_back(mk(0, 0, 0));
    rst = 1'b0;
    for (int n = 0; n < 2 * PERIOD; n++) begin
      tick_neg();
      exp_tick = (k % 4 == 3);
      exp_ps   = (k % PERIOD == PERIOD - 1);
      n_checks++;
      if (tick !== exp_tick) begin
        n_fail++;
        $display("FAIL idle_tick k=%0d: got %b, expected %b", k, tick, exp_tick);
      end
      n_checks++;
      if (period_start !== exp_ps || step !== exp_ps) begin
        n_fail++;
        $display("FAIL idle_ps_step k=%0d: ps=%b step=%b, expected %b", k, period_start, step, exp_ps);
      end
      n_checks++;
      if (pwm_out !== 2'b00) begin
        n_fail++;
        $display("FAIL idle_pwm k=%0d: got %b, expected 00", k, pwm_out);
      end
    end
  endtask

  task automatic test_static();
    wait_ps();
    repeat (5) tick_neg();
    write_main(1'b0, MODE_STATIC, 3'd3);
    exp_q.push_back(mk(0, 0, -1));
    exp_q.push_back(mk(12, 0, -1));
    exp_q.push_back(mk(12, 0, -1));
    wait_ps();
    wait_ps();
    repeat (5) tick_neg();
    write_main(1'b0, MODE_STATIC, 3'd7);
    exp_q.push_back(mk(28, 0, -1));
    exp_q.push_back(mk(28, 0, -1));
    wait_ps();
    wait_ps();
    repeat (5) tick_neg();
    write_main(1'b0, MODE_STATIC, 3'd0);
    exp_q.push_back(mk(0, 0, -1));
    exp_q.push_back(mk(0, 0, -1));
    repeat (3) wait_ps();
  endtask

  task automatic test_off();
    wait_ps();
    repeat (5) tick_neg();
    write_main(1'b0, MODE_STATIC, 3'd7);
    exp_q.push_back(mk(0, 0, -1));
    wait_ps();
    exp_q.push_back(mk(-1, 0, -1));
    repeat (2) tick_neg();
    n_checks++;
    if (pwm_out[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL off_before: pwm0=%b, expected 1", pwm_out[0]);
    end
    write_main(1'b0, MODE_OFF, 3'd7);
    tick_neg();
    n_checks++;
    if (pwm_out[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL off_after: pwm0=%b, expected 0", pwm_out[0]);
    end
    exp_q.push_back(mk(0, 0, -1));
    repeat (2) wait_ps();
  endtask

  task automatic test_ramp();
    int tri_seq [11] = '{6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
    int saw_seq [11] = '{6, 7, 0, 1, 2, 3, 4, 5, 6, 7, 0};
    wait_ps();
    repeat (5) tick_neg();
    write_main(1'b1, MODE_TRI, 3'd6);
    write_main(1'b0, MODE_SAW, 3'd6);
    exp_q.push_back(mk(-1, 0, -1));
    for (int i = 0; i < 11; i++) exp_q.push_back(mk(saw_seq[i] * 4, tri_seq[i] * 4, -1));
    repeat (12) wait_ps();
  endtask

  task automatic test_reset_midramp();
    repeat (9) tick_neg();
    rst = 1'b1;
    tick_neg();
    n_checks++;
    if (pwm_out !== 2'b00 || tick !== 1'b0 || period_start !== 1'b0 || step !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_pulse: pwm=%b tick=%b ps=%b step=%b, expected all 0", pwm_out, tick, period_start, step);
    end
    rst = 1'b0;
    exp_q.delete();
    exp_b_q.delete();
    for (int n = 0; n < PERIOD; n++) begin
      tick_neg();
      n_checks++;
      if (tick !== (k % 4 == 3) || period_start !== (k == PERIOD - 1) || pwm_out !== 2'b00) begin
        n_fail++;
        $display("FAIL rst_restart k=%0d: tick=%b ps=%b pwm=%b, expected tick=%b ps=%b pwm=00",
                 k, tick, period_start, pwm_out, (k % 4 == 3), (k == PERIOD - 1));
      end
    end
  endtask

  task automatic test_ramp3();
    logic exp_ps, exp_step;
    for (int n = 0; n < 6 * PERIOD; n++) begin
      tick_neg();
      exp_ps   = (k % PERIOD == PERIOD - 1);
      exp_step = exp_ps && ((k / PERIOD) % 3 == 2);
      n_checks++;
      if (period_start_b !== exp_ps || step_b !== exp_step) begin
        n_fail++;
        $display("FAIL ramp3 k=%0d: ps=%b step=%b, expected ps=%b step=%b", k, period_start_b, step_b, exp_ps, exp_step);
      end
    end
  endtask

  task automatic test_back_to_back();
    wait_ps();
    repeat (5) tick_neg();
    write_main(1'b0, MODE_SAW, 3'd2);
    write_main(1'b1, MODE_TRI, 3'd5);
    exp_q.push_back(mk(0, 0, -1));
    exp_q.push_back(mk(8, 20, -1));
    exp_q.push_back(mk(12, 24, -1));
    exp_q.push_back(mk(16, 4, -1));
    exp_q.push_back(mk(20, 4, -1));
    wait_ps();
    wait_ps();
    n_checks++;
    if (step !== 1'b1) begin
      n_fail++;
      $display("FAIL collide_step: step=%b, expected 1", step);
    end
    write_main(1'b1, MODE_STATIC, 3'd1);
    repeat (3) wait_ps();
  endtask

  task automatic test_invalid_write();
    wait_ps();
    repeat (5) tick_neg();
    write_b(2'd0, MODE_STATIC, 3'd5);
    exp_b_q.push_back(mk(0, 0, 0));
    wait_ps();
    repeat (5) tick_neg();
    write_b(2'd3, MODE_STATIC, 3'd7);
    exp_b_q.push_back(mk(20, 0, 0));
    exp_b_q.push_back(mk(20, 0, 0));
    repeat (2) wait_ps();
  endtask

  initial begin
    test_reset();
    test_idle();
    test_static();
    test_off();
    test_ramp();
    test_reset_midramp();
    test_ramp3();
    test_back_to_back();
    test_invalid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
